dispatch_scheduler: RTL and testbench
=====================================

# dispatch_scheduler

Dual-issue dispatch scheduler that sits between instruction fetch and `relayer_unit`. It buffers fetched instruction pairs in a small ring queue and presents the two oldest entries to the relayer each cycle. Using the relayer's `issingleinstr` and `isstall` verdicts, it retires 2, 1 or 0 entries from the queue, so an instruction the relayer cannot dual-issue is re-presented in slot 1 on the next cycle.

## Interface
- `IW`, 16, instruction width.
- `DEPTH`, 4, queue entries; power of two, ≥4.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `flush`  in  1  synchronous queue clear (branch redirect).
- `fetch_valid`  in  1  fetch offers a pair.
- `fetch_instr1`  in  IW  older fetched instruction.
- `fetch_instr2`  in  IW  younger fetched instruction.
- `fetch_ready`  out  1  queue can accept a pair.
- `rel_instr1`  out  IW  slot-1 instruction to relayer `instr1_in`.
- `rel_instr2`  out  IW  slot-2 instruction to relayer `instr2_in`.
- `rel_issingle`  in  1  relayer `issingleinstr`.
- `rel_stall`  in  1  relayer `isstall`.
- `issue_valid`  out  1  slot 1 holds a real queued instruction.
- `issue_cnt`  out  2  entries retired this cycle: 0, 1 or 2.
- `occupancy`  out  $clog2(DEPTH)+1  registered entry count.

## Operation
- Queue state: `rd_ptr` and `wr_ptr`, each $clog2(DEPTH) bits with modulo wrap, plus `count`.
- Presentation (combinational from queue state):
  - count ≥2: slot 1 = entry[rd_ptr], slot 2 = entry[rd_ptr+1].
  - count ==1: slot 1 = head, slot 2 = NOP (16'h0000).
  - count ==0: both slots NOP; `issue_valid`=0.
- Retire count `issue_cnt`, evaluated in priority order:
  - count==0: 0.
  - `rel_stall`: 0.
  - count==1 or `rel_issingle`: 1.
  - otherwise: 2.
- Push: when `fetch_valid && fetch_ready`, write `fetch_instr1` at `wr_ptr` and `fetch_instr2` at `wr_ptr+1`; `wr_ptr` += 2.
- `fetch_ready` = (DEPTH − count ≥ 2), computed from the registered count only. Same-cycle retirement does not raise it.
- Simultaneous push and retire are legal: count_next = count + 2·push − issue_cnt; `rd_ptr` += issue_cnt.
- `flush`: pointers and count go to 0 at the next edge. A push or retire in the same cycle is discarded. `fetch_ready` remains a function of pre-flush count during that cycle.
- Queue storage has no reset; only pointers and count are reset.

## Timing
- Reset values: `occupancy`=0, `issue_valid`=0, `issue_cnt`=0, `rel_instr1`=`rel_instr2`=16'h0000, `fetch_ready`=1.
- Reset asserted mid-operation clears pointers and count immediately, without waiting for a clock edge. Outputs return to reset values within the same cycle.
- Push-to-present latency: a pair accepted at edge N is on `rel_instr*` during cycle N+1 if the queue was empty.
- Relayer verdict to retire: `issue_cnt` is combinational from `rel_*` and count; pointers update at the next edge.
- The relayer path is purely combinational. This is a zero-cycle loop: slot outputs → relayer → `rel_*` → `issue_cnt`. `rel_*` must not feed back into `rel_instr*` within a cycle, so `issue_cnt` drives only register enables.
- Full queue (count==DEPTH): `fetch_ready`=0; retirement is still allowed.
- Wrap: a pair pushed at `wr_ptr`=DEPTH−1 occupies entries DEPTH−1 and 0. The slot-2 read at `rd_ptr`=DEPTH−1 comes from entry 0.

## Structure
- Package `dispatch_pkg` holds:
  - `IW` default.
  - `NOP_INSTR` = 16'h0000.
  - Typedef `instr_t` (logic [IW−1:0]).
- Sub-module `instr_pair_fifo` is natural. It provides the dual-write, dual-read ring with variable pop count 0–2 and exports count, head0 and head1.
- `dispatch_scheduler` adds presentation muxing, retire decode and flush.

## Test plan
- Reset then idle: `rst_n`=0 → all outputs at reset values. Release with no fetch → `issue_valid`=0, both slots 16'h0000.
- Dual issue: push (1234, 5678), relayer flags 0/0 → next cycle slots show 1234/5678, `issue_cnt`=2. Following cycle `occupancy`=0.
- Single issue: push (8F34, 8F78) with `rel_issingle`=1 → cycle 1 retires 8F34. Cycle 2 slot 1 = 8F78, slot 2 = NOP, `issue_cnt`=1.
- Stall hold: push (AAAA, BBBB), `rel_stall`=1 for 3 cycles → slots unchanged and `issue_cnt`=0 throughout. Releasing the stall then gives `issue_cnt`=2.
- Full and wrap: stall held while pushing 3 pairs → `fetch_ready` drops at `occupancy`=4 and the third pair is not accepted. Then alternate single retires and pushes across the index wrap → instructions emerge strictly in fetch order.
- Flush and async reset: with `occupancy`=3, assert `flush` together with `fetch_valid` → next cycle `occupancy`=0 and the pushed pair is dropped. Pulse `rst_n` low between edges → `occupancy` reads 0 immediately.

Source files
------------

// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and constants for the dual-issue dispatch scheduler.
package dispatch_pkg;

  localparam int IW = 16;

  typedef logic [IW-1:0] instr_t;

  // Slots with no real instruction behind them carry this encoding.
  localparam instr_t NOP_INSTR = 16'h0000;

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Fetch-side and relayer-side signals of the dispatch scheduler.
// The scheduler connects through the slave modport. Fetch and the relayer
// (or a testbench standing in for them) connect through the master modport.
interface dispatch_scheduler_if #(
  parameter int IW    = 16,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          fetch_valid;
  logic [IW-1:0] fetch_instr1;
  logic [IW-1:0] fetch_instr2;
  logic          fetch_ready;

  logic [IW-1:0] rel_instr1;
  logic [IW-1:0] rel_instr2;
  logic          rel_issingle;
  logic          rel_stall;

  logic          issue_valid;
  logic [1:0]    issue_cnt;
  logic [CW-1:0] occupancy;

  modport master (
    output fetch_valid, fetch_instr1, fetch_instr2, rel_issingle, rel_stall,
    input  fetch_ready, rel_instr1, rel_instr2, issue_valid, issue_cnt, occupancy
  );

  modport slave (
    input  fetch_valid, fetch_instr1, fetch_instr2, rel_issingle, rel_stall,
    output fetch_ready, rel_instr1, rel_instr2, issue_valid, issue_cnt, occupancy
  );

endinterface

// File: rtl/dispatch_scheduler_fifo.sv
// Ring queue of instructions.
// Each push writes a pair, and each cycle pops 0, 1 or 2 entries.
// The two oldest entries are always visible as head0/head1.
module instr_pair_fifo
  import dispatch_pkg::*;
#(
  parameter int IW    = dispatch_pkg::IW,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [IW-1:0]            din0,
  input  logic [IW-1:0]            din1,
  input  logic [1:0]               pop_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [IW-1:0]            head0,
  output logic [IW-1:0]            head1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] push_amt;

  assign push_amt = push ? CW'(2) : '0;

  // Pointer and count bookkeeping. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(2);
      end
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + push_amt - CW'(pop_cnt);
    end
  end

  // Storage is written without reset. Only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]          <= din0;
      mem[wr_ptr + PW'(1)] <= din1;
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/dispatch_scheduler.sv
// Dual-issue dispatch scheduler.
// It queues fetched pairs and presents the two oldest entries to the relayer.
// It then retires 0, 1 or 2 of them based on the relayer's verdict.
module dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter int IW    = dispatch_pkg::IW,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  dispatch_scheduler_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] NOP = IW'(NOP_INSTR);

  logic [CW-1:0] count;
  logic [IW-1:0] head0;
  logic [IW-1:0] head1;
  logic          push;
  logic [1:0]    retire_cnt;

  // Readiness uses only the registered count, so a retire in the same cycle
  // never opens room early and the relayer loop stays out of the fetch path.
  assign bus.fetch_ready = (count <= CW'(DEPTH - 2));
  assign push            = bus.fetch_valid && bus.fetch_ready && !flush;
  assign bus.occupancy   = count;
  assign bus.issue_cnt   = retire_cnt;

  instr_pair_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (push),
    .din0    (bus.fetch_instr1),
    .din1    (bus.fetch_instr2),
    .pop_cnt (retire_cnt),
    .count   (count),
    .head0   (head0),
    .head1   (head1)
  );

  // Slot presentation depends on queue state only, never on the relayer verdict.
  always_comb begin
    bus.rel_instr1  = NOP;
    bus.rel_instr2  = NOP;
    bus.issue_valid = 1'b0;
    if (count >= CW'(2)) begin
      bus.rel_instr1  = head0;
      bus.rel_instr2  = head1;
      bus.issue_valid = 1'b1;
    end else if (count == CW'(1)) begin
      bus.rel_instr1  = head0;
      bus.issue_valid = 1'b1;
    end
  end

  // Retire decode. Empty or stalled retires nothing. A lone entry or a
  // single-issue verdict retires one. Otherwise both slots go.
  always_comb begin
    retire_cnt = 2'd2;
    if (count == '0 || bus.rel_stall) begin
      retire_cnt = 2'd0;
    end else if (count == CW'(1) || bus.rel_issingle) begin
      retire_cnt = 2'd1;
    end
  end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard testbench for dispatch_scheduler: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_dispatch_scheduler;
  import dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    instr_t        slot1;
    instr_t        slot2;
    logic          valid;
    logic [1:0]    cnt;
    logic [CW-1:0] occ;
    logic          ready;
  } expect_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;

  instr_t  model_q[$];
  expect_t exp_q[$];

  dispatch_scheduler_if #(.IW(IW), .DEPTH(DEPTH)) bus ();

  dispatch_scheduler #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the value the bench requires.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour: the queue holds instructions oldest first. Slots show
  // the front two entries. The retire rule is applied to the number held.
  function automatic expect_t predict(input logic single, input logic stall);
    expect_t e;
    int n;
    n       = model_q.size();
    e.slot1 = (n >= 1) ? model_q[0] : NOP_INSTR;
    e.slot2 = (n >= 2) ? model_q[1] : NOP_INSTR;
    e.valid = (n > 0);
    e.ready = ((DEPTH - n) >= 2);
    e.occ   = CW'(n);
    if (n == 0 || stall)        e.cnt = 2'd0;
    else if (n == 1 || single)  e.cnt = 2'd1;
    else                        e.cnt = 2'd2;
    return e;
  endfunction

  task automatic checkOutput(input expect_t e);
    compare("rel_instr1",  32'(bus.rel_instr1),  32'(e.slot1));
    compare("rel_instr2",  32'(bus.rel_instr2),  32'(e.slot2));
    compare("issue_valid", 32'(bus.issue_valid), 32'(e.valid));
    compare("issue_cnt",   32'(bus.issue_cnt),   32'(e.cnt));
    compare("occupancy",   32'(bus.occupancy),   32'(e.occ));
    compare("fetch_ready", 32'(bus.fetch_ready), 32'(e.ready));
  endtask

  // Drive one cycle of inputs, queue the expected response, then advance the
  // model across the clock edge.
  task automatic applyStimulus(input logic fv, input instr_t i1, input instr_t i2,
                               input logic single, input logic stall, input logic fl);
    expect_t e;
    bus.fetch_valid  = fv;
    bus.fetch_instr1 = i1;
    bus.fetch_instr2 = i2;
    bus.rel_issingle = single;
    bus.rel_stall    = stall;
    flush            = fl;
    e = predict(single, stall);
    exp_q.push_back(e);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      for (int k = 0; k < int'(e.cnt); k++) void'(model_q.pop_front());
      if (fv && e.ready) begin
        model_q.push_back(i1);
        model_q.push_back(i2);
      end
    end
    #1;
  endtask

  // Pulse reset between edges and confirm that the queue empties at once.
  task automatic asyncReset();
    bus.fetch_valid  = 1'b0;
    bus.rel_issingle = 1'b0;
    bus.rel_stall    = 1'b0;
    flush            = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    compare("async_occupancy",   32'(bus.occupancy),   32'd0);
    compare("async_issue_valid", 32'(bus.issue_valid), 32'd0);
    compare("async_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    compare("async_rel_instr1",  32'(bus.rel_instr1),  32'(NOP_INSTR));
    #1;
    rst_n = 1'b1;
    model_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per cycle and compare away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    bus.fetch_valid  = 1'b0;
    bus.fetch_instr1 = '0;
    bus.fetch_instr2 = '0;
    bus.rel_issingle = 1'b0;
    bus.rel_stall    = 1'b0;

    #3;
    compare("reset_occupancy",   32'(bus.occupancy),   32'd0);
    compare("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    compare("reset_issue_cnt",   32'(bus.issue_cnt),   32'd0);
    compare("reset_rel_instr1",  32'(bus.rel_instr1),  32'h0000);
    compare("reset_rel_instr2",  32'(bus.rel_instr2),  32'h0000);
    compare("reset_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h8F34, 16'h8F78, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'hAAAA, 16'hBBBB, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h1001, 16'h1002, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1003, 16'h1004, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1005, 16'h1006, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'(16'h2000 + 2 * i), 16'(16'h2001 + 2 * i), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h3001, 16'h3002, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h3003, 16'h3004, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3005, 16'h3006, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h4001, 16'h4002, 1'b0, 1'b1, 1'b0);
    asyncReset();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60),
                    instr_t'($urandom), instr_t'($urandom),
                    1'($urandom_range(0, 99) < 30),
                    1'($urandom_range(0, 99) < 20),
                    1'($urandom_range(0, 99) < 3));
      if (i % 97 == 50) asyncReset();
    end

    @(negedge clk);
    #1;
    compare("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
